// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: read-before-write RAM controller forming a programmable FIFO delay line of cfg_len+1 samples
module delay_line_ctrl #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] cfg_len,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              primed,
  output logic              mem_ce,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);
  logic [AWIDTH-1:0] wr_ptr, len_q;
  logic [AWIDTH:0]   fill_cnt, fill_nxt, len_p1;
  logic              use_mem, fire, full;
  assign s_ready   = !flush && (!m_valid || m_ready);
  assign fire      = s_valid && s_ready;
  assign mem_ce    = fire;
  assign mem_addr  = wr_ptr;
  assign mem_wdata = s_data;
  assign len_p1    = {1'b0, len_q} + (AWIDTH+1)'(1);
  assign full      = fill_cnt == len_p1;
  assign fill_nxt  = full ? fill_cnt : fill_cnt + (AWIDTH+1)'(1);
  // stale RAM words read before the line fills are masked to zero
  assign m_data    = use_mem ? mem_rdata : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      len_q    <= '1;
      m_valid  <= 1'b0;
      use_mem  <= 1'b0;
      primed   <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      len_q    <= cfg_len;
      m_valid  <= 1'b0;
      use_mem  <= 1'b0;
      primed   <= 1'b0;
    end else if (fire) begin
      wr_ptr   <= wr_ptr == len_q ? '0 : wr_ptr + AWIDTH'(1);
      fill_cnt <= fill_nxt;
      use_mem  <= full;
      primed   <= fill_nxt == len_p1;
      m_valid  <= 1'b1;
    end else if (m_ready) begin
      m_valid  <= 1'b0;
    end
  end
endmodule
